// File: rtl/player_pkg.sv
// Shared colour codes, colour index encoding and FSM state encodings for the player lane controller.
package player_pkg;

    localparam int unsigned DARK    = 31;
    localparam int unsigned COLOR_R = 10;
    localparam int unsigned COLOR_G = 11;
    localparam int unsigned COLOR_B = 12;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        MV_IDLE   = 2'd0,
        MV_DELAY  = 2'd1,
        MV_REPEAT = 2'd2
    } mv_state_e;

    typedef enum logic [1:0] {
        F_READY = 2'd0,
        F_PEND  = 2'd1,
        F_COOL  = 2'd2
    } fire_state_e;

    function automatic int unsigned color_code(input color_e c);
        case (c)
            COL_G:   return COLOR_G;
            COL_B:   return COLOR_B;
            default: return COLOR_R;
        endcase
    endfunction

endpackage

// File: rtl/player_lane_ctrl_lfsr8.sv
// 8-bit right-shifting Galois LFSR, free-running every clock.
module lfsr8
    import player_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign out = r_lfsr;

endmodule

// File: rtl/player_lane_ctrl.sv
// Player lane controller: joystick-driven lane position with auto-repeat, fire/shot handshake
// with cooldown, and a registered per-lane colour row.
module player_lane_ctrl
    import player_pkg::*;
#(
    parameter int COLS           = 8,
    parameter int CW             = 5,
    parameter int WRAP           = 0,
    parameter int REPEAT_TICKS   = 4,
    parameter int FIRST_DELAY    = 8,
    parameter int COOLDOWN_TICKS = 3
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     tick,
    input  logic [3:0]               jstk_pos,
    input  logic                     shot_ready,
    output logic [COLS*CW-1:0]       player_row,
    output logic [$clog2(COLS)-1:0]  player_pos,
    output logic                     shot_valid,
    output logic [$clog2(COLS)-1:0]  shot_col,
    output logic [1:0]               shot_color,
    output logic [COLS-1:0]          pos_onehot
);

    localparam int PW     = $clog2(COLS);
    localparam int MV_MAX = (FIRST_DELAY > REPEAT_TICKS) ? FIRST_DELAY : REPEAT_TICKS;
    localparam int MVW    = $clog2(MV_MAX + 2);
    localparam int CDW    = $clog2(COOLDOWN_TICKS + 2);

    logic [7:0]         w_lfsr;
    color_e             w_lfsr_color;
    logic [1:0]         w_dir;
    logic               w_dir_valid;
    logic [PW-1:0]      w_pos_moved;
    logic               w_fire_edge;
    logic [CW-1:0]      w_code;
    logic [COLS*CW-1:0] w_row;
    logic [6:0]         w_unused;

    mv_state_e          r_mv_state;
    logic [MVW-1:0]     r_mv_cnt;
    logic [1:0]         r_dir;
    logic [PW-1:0]      r_pos;

    fire_state_e        r_f_state;
    logic [CDW-1:0]     r_cd_cnt;
    logic               r_fire_q;
    logic               r_shot_valid;
    logic [PW-1:0]      r_shot_col;
    color_e             r_shot_color;
    color_e             r_loaded;
    logic [COLS*CW-1:0] r_row;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (w_lfsr)
    );

    assign w_unused     = {w_lfsr[7:2], jstk_pos[1]};
    assign w_lfsr_color = (w_lfsr[1:0] == 2'd3) ? COL_R : color_e'(w_lfsr[1:0]);

    // w_dir[0] = left (+1), w_dir[1] = right (-1); both or neither means no direction
    assign w_dir       = jstk_pos[3:2];
    assign w_dir_valid = w_dir[0] ^ w_dir[1];
    assign w_fire_edge = jstk_pos[0] & ~r_fire_q;

    always_comb begin
        w_pos_moved = r_pos;
        if (w_dir == 2'b01) begin
            if (r_pos == PW'(COLS - 1)) begin
                w_pos_moved = (WRAP != 0) ? '0 : r_pos;
            end else begin
                w_pos_moved = r_pos + 1'b1;
            end
        end else if (w_dir == 2'b10) begin
            if (r_pos == '0) begin
                w_pos_moved = (WRAP != 0) ? PW'(COLS - 1) : r_pos;
            end else begin
                w_pos_moved = r_pos - 1'b1;
            end
        end
    end

    // Any change of the held direction (including release) drops back to idle without moving
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mv_state <= MV_IDLE;
            r_mv_cnt   <= '0;
            r_dir      <= '0;
            r_pos      <= PW'(1);
        end else if (en) begin
            case (r_mv_state)
                MV_IDLE: begin
                    if (tick && w_dir_valid) begin
                        r_pos      <= w_pos_moved;
                        r_dir      <= w_dir;
                        r_mv_cnt   <= MVW'(FIRST_DELAY);
                        r_mv_state <= MV_DELAY;
                    end
                end
                MV_DELAY, MV_REPEAT: begin
                    if (w_dir != r_dir) begin
                        r_mv_cnt   <= '0;
                        r_mv_state <= MV_IDLE;
                    end else if (tick) begin
                        if (r_mv_cnt <= MVW'(1)) begin
                            r_pos      <= w_pos_moved;
                            r_mv_cnt   <= MVW'(REPEAT_TICKS);
                            r_mv_state <= MV_REPEAT;
                        end else begin
                            r_mv_cnt <= r_mv_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_mv_cnt   <= '0;
                    r_mv_state <= MV_IDLE;
                end
            endcase
        end
    end

    // The consumer handshake completes even while disabled; everything else waits for en
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_state    <= F_READY;
            r_cd_cnt     <= '0;
            r_fire_q     <= 1'b0;
            r_shot_valid <= 1'b0;
            r_shot_col   <= '0;
            r_shot_color <= COL_R;
            r_loaded     <= COL_R;
        end else begin
            if (en) begin
                r_fire_q <= jstk_pos[0];
            end
            case (r_f_state)
                F_READY: begin
                    if (en && w_fire_edge) begin
                        r_shot_col   <= r_pos;
                        r_shot_color <= r_loaded;
                        r_shot_valid <= 1'b1;
                        r_f_state    <= F_PEND;
                    end
                end
                F_PEND: begin
                    if (shot_ready) begin
                        r_shot_valid <= 1'b0;
                        r_cd_cnt     <= CDW'(COOLDOWN_TICKS);
                        r_f_state    <= F_COOL;
                    end
                end
                F_COOL: begin
                    if (en && tick) begin
                        if (r_cd_cnt <= CDW'(1)) begin
                            r_cd_cnt  <= '0;
                            r_loaded  <= w_lfsr_color;
                            r_f_state <= F_READY;
                        end else begin
                            r_cd_cnt <= r_cd_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_shot_valid <= 1'b0;
                    r_f_state    <= F_READY;
                end
            endcase
        end
    end

    assign w_code = CW'(color_code(r_loaded));

    always_comb begin
        w_row = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            w_row[i*CW +: CW] = (r_pos == PW'(i)) ? w_code : CW'(DARK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                r_row[i*CW +: CW] <= (i == 1) ? CW'(COLOR_R) : CW'(DARK);
            end
        end else if (en) begin
            r_row <= w_row;
        end
    end

    always_comb begin
        pos_onehot        = '0;
        pos_onehot[r_pos] = 1'b1;
    end

    assign player_row = r_row;
    assign player_pos = r_pos;
    assign shot_valid = r_shot_valid;
    assign shot_col   = r_shot_col;
    assign shot_color = r_shot_color;

endmodule
